frame_stream_parser: RTL and testbench

FRAME_STREAM_PARSER -- requirements
Module: frame_stream_parser

---
 rtl/frame_stream_parser_if.sv | 22 ++
 rtl/frame_stream_parser.sv | 177 +++++++++++++++++
 tb/tb_frame_stream_parser.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_stream_parser_if.sv
// Bundles the FWFT FIFO read side and the outgoing stream of the frame parser.
// master: the parser's view (pops the FIFO, drives the stream).
// slave: the environment's view (supplies FIFO words, accepts the stream).
interface frame_stream_parser_if;
  logic        fifo_empty;
  logic [31:0] fifo_read_data;
  logic        fifo_read_en;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;

  modport master (
    input  fifo_empty, fifo_read_data, m_tready,
    output fifo_read_en, m_tdata, m_tvalid, m_tlast
  );

  modport slave (
    output fifo_empty, fifo_read_data, m_tready,
    input  fifo_read_en, m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/frame_stream_parser.sv
// Hunts a two-word magic header in a FWFT FIFO and forwards each frame as a stream with tlast.
// Latency: header words are replayed from registers; payload is a zero-cycle pass-through.
// Backpressure: m_tready gates every transfer; an empty FIFO stalls silently. Optional macro TIMESTAMP_CHECK_EN.
module frame_stream_parser #(
  parameter int          FRAME_WORDS = 144,
  parameter logic [31:0] MAGIC_LO    = 32'hDEADBEEF,
  parameter logic [31:0] MAGIC_HI    = 32'hCAFEBABE
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        enable,
  input  logic                        clear_counters,
  frame_stream_parser_if.master       bus,
  output logic [31:0]                 frames_ok,
  output logic [31:0]                 magic_errors,
  output logic [31:0]                 ts_gaps,
  output logic [63:0]                 last_timestamp,
  output logic [2:0]                  parser_state
);

  typedef enum logic [2:0] {
    HUNT     = 3'd0,
    CHECK_HI = 3'd1,
    EMIT_LO  = 3'd2,
    EMIT_HI  = 3'd3,
    PASS     = 3'd4
  } state_t;

  localparam int             IDX_W    = $clog2(FRAME_WORDS);
  // Index of the final pass-through word; the two header words were replayed from registers.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 3);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        frames_q, frames_d;
  logic [31:0]        magic_q, magic_d;
  logic [63:0]        ts_q, ts_d;
  logic               pop;
  logic               tvalid;
  logic               tlast;
  logic [31:0]        tdata;

`ifdef TIMESTAMP_CHECK_EN
  logic [31:0]        gaps_q, gaps_d;
  logic [63:0]        prev_ts_q, prev_ts_d;
  logic               ts_vld_q, ts_vld_d;
  logic [63:0]        new_ts;
`endif

  // Next-state, counter and stream output decode.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    frames_d = frames_q;
    magic_d  = magic_q;
    ts_d     = ts_q;
    pop      = 1'b0;
    tvalid   = 1'b0;
    tlast    = 1'b0;
    tdata    = 32'h0;
`ifdef TIMESTAMP_CHECK_EN
    gaps_d    = gaps_q;
    prev_ts_d = prev_ts_q;
    ts_vld_d  = ts_vld_q;
    new_ts    = {bus.fifo_read_data, ts_q[31:0]};
`endif
    case (state_q)
      HUNT: begin
        if (enable && !bus.fifo_empty) begin
          pop = 1'b1;
          if (bus.fifo_read_data == MAGIC_LO) state_d = CHECK_HI;
          else                                magic_d = magic_q + 32'd1;
        end
      end
      CHECK_HI: begin
        if (!bus.fifo_empty) begin
          pop = 1'b1;
          // A repeated MAGIC_LO may itself be the start of the real header.
          if (bus.fifo_read_data == MAGIC_HI) begin
            state_d = EMIT_LO;
          end else if (bus.fifo_read_data != MAGIC_LO) begin
            state_d = HUNT;
            magic_d = magic_q + 32'd1;
          end
        end
      end
      EMIT_LO: begin
        tvalid = 1'b1;
        tdata  = MAGIC_LO;
        if (bus.m_tready) state_d = EMIT_HI;
      end
      EMIT_HI: begin
        tvalid = 1'b1;
        tdata  = MAGIC_HI;
        if (bus.m_tready) begin
          state_d = PASS;
          idx_d   = '0;
        end
      end
      PASS: begin
        tdata  = bus.fifo_read_data;
        tvalid = !bus.fifo_empty;
        tlast  = !bus.fifo_empty && (idx_q == LAST_IDX);
        pop    = bus.m_tready && !bus.fifo_empty;
        if (pop) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_W'(0)) ts_d[31:0]  = bus.fifo_read_data;
          if (idx_q == IDX_W'(1)) begin
            ts_d[63:32] = bus.fifo_read_data;
`ifdef TIMESTAMP_CHECK_EN
            if (ts_vld_q && (new_ts != prev_ts_q + 64'd1)) gaps_d = gaps_q + 32'd1;
            prev_ts_d = new_ts;
            ts_vld_d  = 1'b1;
`endif
          end
          if (idx_q == LAST_IDX) begin
            state_d  = HUNT;
            idx_d    = '0;
            frames_d = frames_q + 32'd1;
          end
        end
      end
      default: state_d = HUNT;
    endcase
    if (clear_counters) begin
      frames_d = 32'h0;
      magic_d  = 32'h0;
`ifdef TIMESTAMP_CHECK_EN
      gaps_d   = 32'h0;
`endif
    end
  end

  // State, index, counters and timestamp registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= HUNT;
      idx_q    <= '0;
      frames_q <= 32'h0;
      magic_q  <= 32'h0;
      ts_q     <= 64'h0;
`ifdef TIMESTAMP_CHECK_EN
      gaps_q    <= 32'h0;
      prev_ts_q <= 64'h0;
      ts_vld_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      frames_q <= frames_d;
      magic_q  <= magic_d;
      ts_q     <= ts_d;
`ifdef TIMESTAMP_CHECK_EN
      gaps_q    <= gaps_d;
      prev_ts_q <= prev_ts_d;
      ts_vld_q  <= ts_vld_d;
`endif
    end
  end

  // Outputs are held at zero while reset is asserted so nothing pops or transfers.
  assign bus.fifo_read_en = rstn & pop;
  assign bus.m_tvalid     = rstn & tvalid;
  assign bus.m_tlast      = rstn & tlast;
  assign bus.m_tdata      = rstn ? tdata : 32'h0;

  assign frames_ok      = frames_q;
  assign magic_errors   = magic_q;
  assign last_timestamp = ts_q;
  assign parser_state   = state_q;
`ifdef TIMESTAMP_CHECK_EN
  assign ts_gaps        = gaps_q;
`else
  assign ts_gaps        = 32'h0;
`endif

endmodule

// File: tb/tb_frame_stream_parser.sv
// Directed bench for frame_stream_parser: FWFT FIFO model, stream capture, counter checks.
// Each step drives inputs just after a rising edge and samples outputs before the next one.
// Expected streams are rebuilt from the pushed frame contents.
module tb_frame_stream_parser;
  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic        clear_counters;
  logic [31:0] frames_ok, magic_errors, ts_gaps;
  logic [63:0] last_timestamp;
  logic [2:0]  parser_state;

  frame_stream_parser_if ifc ();

  frame_stream_parser dut (
    .clk            (clk),
    .rstn           (rstn),
    .enable         (enable),
    .clear_counters (clear_counters),
    .bus            (ifc.master),
    .frames_ok      (frames_ok),
    .magic_errors   (magic_errors),
    .ts_gaps        (ts_gaps),
    .last_timestamp (last_timestamp),
    .parser_state   (parser_state)
  );

  always #5 clk = ~clk;

  logic [31:0] fifo_q[$];
  logic [31:0] pend_q[$];
  logic [31:0] exp_d[$];
  logic        exp_l[$];
  logic [31:0] out_d[$];
  logic        out_l[$];
  int          checks = 0;
  int          errors = 0;
  int          bad_pop = 0;
  int          npop = 0;
  bit          rnd_ready = 1'b0;
  logic [31:0] gaps_exp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic refresh();
    ifc.fifo_empty     = (fifo_q.size() == 0);
    ifc.fifo_read_data = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
  endtask

  // One clock step: capture transfers, check pop discipline, advance, apply the pop.
  task automatic tick();
    bit pop;
    #1;
    if (ifc.m_tvalid && ifc.m_tready) begin
      out_d.push_back(ifc.m_tdata);
      out_l.push_back(ifc.m_tlast);
    end
    if (parser_state >= 3'd2 && parser_state <= 3'd4)
      if (ifc.fifo_read_en !== (parser_state == 3'd4 && ifc.m_tvalid && ifc.m_tready)) bad_pop++;
    pop = ifc.fifo_read_en && !ifc.fifo_empty;
    if (pop) npop++;
    @(posedge clk);
    #1;
    if (pop) void'(fifo_q.pop_front());
    if (rnd_ready) ifc.m_tready = 1'($urandom_range(0, 1));
    refresh();
  endtask

  task automatic push_frame(input logic [63:0] ts, input bit magic_payload);
    logic [31:0] w;
    for (int k = 0; k < 144; k++) begin
      if (k == 0)      w = 32'hDEADBEEF;
      else if (k == 1) w = 32'hCAFEBABE;
      else if (k == 2) w = ts[31:0];
      else if (k == 3) w = ts[63:32];
      else if (magic_payload && k == 20) w = 32'hDEADBEEF;
      else if (magic_payload && k == 21) w = 32'hCAFEBABE;
      else w = {ts[15:0], 16'(k * 7 + 3)};
      pend_q.push_back(w);
      exp_d.push_back(w);
      exp_l.push_back(k == 143);
    end
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n && pend_q.size() != 0; i++) fifo_q.push_back(pend_q.pop_front());
    refresh();
  endtask

  task automatic push_raw(input logic [31:0] w);
    fifo_q.push_back(w);
    refresh();
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((fifo_q.size() != 0 || parser_state != 3'd0) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 64'(n < budget), 64'd1);
  endtask

  function automatic int count_bad(input int n);
    int b = 0;
    for (int i = 0; i < n; i++)
      if (i >= out_d.size() || i >= exp_d.size() || out_d[i] !== exp_d[i] || out_l[i] !== exp_l[i]) b++;
    return b;
  endfunction

  task automatic check_frames(input string tag);
    chk({tag, "_len"}, 64'(out_d.size()), 64'(exp_d.size()));
    chk({tag, "_data"}, 64'(count_bad(exp_d.size())), 64'd0);
    out_d.delete(); out_l.delete(); exp_d.delete(); exp_l.delete();
  endtask

  task automatic clear_cnt();
    clear_counters = 1'b1;
    tick();
    clear_counters = 1'b0;
  endtask

  initial begin
    int n;
    rstn = 1'b0; enable = 1'b1; clear_counters = 1'b0;
    ifc.m_tready = 1'b1;
    refresh();
`ifdef TIMESTAMP_CHECK_EN
    gaps_exp = 32'd1;
`else
    gaps_exp = 32'd0;
`endif

    // Reset state
    tick(); tick();
    chk("rst_state", 64'(parser_state), 64'd0);
    chk("rst_tvalid", 64'(ifc.m_tvalid), 64'd0);
    chk("rst_tdata", 64'(ifc.m_tdata), 64'd0);
    chk("rst_rden", 64'(ifc.fifo_read_en), 64'd0);
    chk("rst_frames", 64'(frames_ok), 64'd0);
    chk("rst_ts", last_timestamp, 64'd0);
    rstn = 1'b1;
    tick();

    // Single clean frame, ts 5
    push_frame(64'd5, 1'b0); feed(144);
    drain("f1_done", 1000);
    check_frames("f1");
    chk("f1_frames", 64'(frames_ok), 64'd1);
    chk("f1_magic", 64'(magic_errors), 64'd0);
    chk("f1_ts", last_timestamp, 64'd5);
    chk("f1_gaps", 64'(ts_gaps), 64'd0);

    // Junk, broken header, then a good frame
    clear_cnt();
    chk("clr_frames", 64'(frames_ok), 64'd0);
    push_raw(32'h1); push_raw(32'h2); push_raw(32'h3);
    push_raw(32'hDEADBEEF); push_raw(32'h12345678);
    push_frame(64'd5, 1'b0); feed(144);
    drain("f2_done", 1000);
    check_frames("f2");
    chk("f2_magic", 64'(magic_errors), 64'd4);
    chk("f2_frames", 64'(frames_ok), 64'd1);

    // Repeated MAGIC_LO before the header; magic words inside payload
    clear_cnt();
    push_raw(32'hDEADBEEF);
    push_frame(64'd6, 1'b1); feed(144);
    drain("f3_done", 1000);
    check_frames("f3");
    chk("f3_magic", 64'(magic_errors), 64'd0);
    chk("f3_frames", 64'(frames_ok), 64'd1);

    // Timestamps 7, 8, 10 following 6
    clear_cnt();
    push_frame(64'd7, 1'b0); push_frame(64'd8, 1'b0); push_frame(64'd10, 1'b0); feed(432);
    drain("f4_done", 2000);
    check_frames("f4");
    chk("f4_gaps", 64'(ts_gaps), 64'(gaps_exp));
    chk("f4_frames", 64'(frames_ok), 64'd3);
    chk("f4_ts", last_timestamp, 64'd10);

    // Random ready with the FIFO running dry mid-frame
    clear_cnt();
    bad_pop = 0;
    rnd_ready = 1'b1;
    push_frame(64'h0000_0002_0000_000B, 1'b0); feed(60);
    n = 0;
    while (fifo_q.size() != 0 && n < 1000) begin tick(); n++; end
    chk("f5_dry", 64'(n < 1000), 64'd1);
    for (int i = 0; i < 10; i++) tick();
    chk("f5_stall_state", 64'(parser_state), 64'd4);
    chk("f5_stall_vld", 64'(ifc.m_tvalid), 64'd0);
    feed(144);
    drain("f5_done", 2000);
    rnd_ready = 1'b0; ifc.m_tready = 1'b1;
    check_frames("f5");
    chk("f5_pops", 64'(bad_pop), 64'd0);
    chk("f5_frames", 64'(frames_ok), 64'd1);
    chk("f5_magic", 64'(magic_errors), 64'd0);
    chk("f5_ts", last_timestamp, 64'h0000_0002_0000_000B);

    // Enable drop mid-frame, then reset mid-frame
    clear_cnt();
    push_frame(64'd12, 1'b0); feed(144);
    push_frame(64'd13, 1'b0); feed(144);
    n = 0;
    while (out_d.size() < 50 && n < 1000) begin tick(); n++; end
    chk("f6_w50", 64'(n < 1000), 64'd1);
    enable = 1'b0;
    n = 0;
    while ((out_d.size() < 144 || parser_state != 3'd0) && n < 1000) begin tick(); n++; end
    chk("f6_finish", 64'(n < 1000), 64'd1);
    chk("f6_data", 64'(count_bad(144)), 64'd0);
    npop = 0;
    for (int i = 0; i < 20; i++) tick();
    chk("f6_idle_pops", 64'(npop), 64'd0);
    chk("f6_depth", 64'(fifo_q.size()), 64'd144);
    chk("f6_frames", 64'(frames_ok), 64'd1);
    enable = 1'b1;
    n = 0;
    while (out_d.size() < 164 && n < 1000) begin tick(); n++; end
    chk("f7_w20", 64'(n < 1000), 64'd1);
    rstn = 1'b0; enable = 1'b0;
    tick();
    chk("f7_rst_state", 64'(parser_state), 64'd0);
    chk("f7_rst_tvalid", 64'(ifc.m_tvalid), 64'd0);
    chk("f7_rst_tlast", 64'(ifc.m_tlast), 64'd0);
    chk("f7_rst_tdata", 64'(ifc.m_tdata), 64'd0);
    chk("f7_rst_frames", 64'(frames_ok), 64'd0);
    chk("f7_rst_ts", last_timestamp, 64'd0);
    rstn = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) tick();
    for (int i = 0; i < out_l.size(); i++) if (out_l[i]) n++;
    chk("f7_tlast_count", 64'(n), 64'd1);
    chk("f7_idle_state", 64'(parser_state), 64'd0);
    chk("f7_idle_tvalid", 64'(ifc.m_tvalid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
